// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline register and RUN/STALL/FLUSH tracker for a MIPS-style fetch.
// Optional stall/flush statistics counters are built only with FETCH_STATS_EN defined.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcenable,
  input  logic        idifenable,
  input  logic        ifidNOP,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instructionFetch,
  output logic [31:0] pc_plus4_id,
  output logic        ifid_valid,
  output logic [1:0]  fetch_state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);
  localparam logic [31:0] NOP = 32'hFC00_0000;
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, pc_nxt, pc4;
  logic flush;
  always_comb begin
    pc4 = pc + 32'd4;
    flush = branch_taken | jump_valid | ifidNOP;
    pc_nxt = branch_taken ? (branch_target & ~32'd3) :
             jump_valid   ? {pc_plus4_id[31:28], jump_index, 2'b00} :
             pcenable     ? pc4 : pc;
    state_nxt = flush ? FLUSH : !pcenable ? STALL : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      state <= RUN;
    end else begin
      pc <= pc_nxt;
      state <= state_nxt;
    end
  end
  // A flush wins over a simultaneous hold so a squashed slot never survives a stall.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instructionFetch <= NOP;
      pc_plus4_id <= '0;
      ifid_valid <= 1'b0;
    end else if (idifenable) begin
      instructionFetch <= imem_data;
      pc_plus4_id <= pc4;
      ifid_valid <= 1'b1;
    end
  end
  assign imem_addr = pc;
  assign fetch_state = state;
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (state_nxt == STALL && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      if (state_nxt == FLUSH && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif
endmodule
